// File: rtl/rv_pkg.sv
// Shared RV integer-core definitions: register addressing, data width and
// the write-back request payload.
package rv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 32;

   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

   // One write-back result: destination register and value
   typedef struct packed {
      reg_addr_t        rd;
      logic [XLEN-1:0]  data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter for the write-back port.
// Default: round-robin with an internal priority pointer that moves to one
// past the last winner. With WB_FIXED_PRIO_EN defined: fixed priority,
// lowest index wins, and no pointer exists.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   gnt_c      : combinational one-hot grant (zero when no request)
module rr_arbiter
   import rv_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt_c
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef WB_FIXED_PRIO_EN

   logic found_c;
   logic unused_clk_rst;

   // No state in fixed-priority mode
   assign unused_clk_rst = clk ^ rst_n;

   // Lowest requesting index wins
   always_comb begin
      gnt_c   = '0;
      found_c = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found_c && req[i]) begin
            gnt_c[i] = 1'b1;
            found_c  = 1'b1;
         end
      end
   end

`else

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_nxt_c;
   logic             found_c;
   int unsigned      idx_c;

   // Search ptr, ptr+1, ... modulo NUM_REQ; first requester wins
   always_comb begin
      gnt_c     = '0;
      ptr_nxt_c = ptr;
      found_c   = 1'b0;
      idx_c     = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx_c = 32'(ptr) + k;
         if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
         if (!found_c && req[PTR_W'(idx_c)]) begin
            found_c              = 1'b1;
            gnt_c[PTR_W'(idx_c)] = 1'b1;
            ptr_nxt_c            = (idx_c == NUM_REQ - 1) ? '0 : PTR_W'(idx_c + 1);
         end
      end
   end

   // Priority pointer; holds when nothing is granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_nxt_c;
   end

`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the 32x32 integer register file.
// Arbitrates NUM_SRC result sources onto the single register file write
// port through a registered output stage, and tracks destination registers
// with writes in flight (busy_vec) for hazard stalling at issue.
// Arbitration: round-robin by default; define WB_FIXED_PRIO_EN for fixed
// lowest-index-wins priority.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   alloc_valid, alloc_rd : issue allocates a destination register
//   src_valid/rd/data     : per-source result request (flattened vectors)
//   src_ready             : combinational one-hot acceptance
//   wr_en/rd_addr/rd_data : registered register file write port
//   busy_vec              : pending-write bit per register, bit 0 always 0
module regfile_wb_ctrl
   import rv_pkg::*;
#(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned XLEN    = rv_pkg::XLEN
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alloc_valid,
   input  reg_addr_t                 alloc_rd,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic [NUM_SRC*REG_AW-1:0] src_rd,
   input  logic [NUM_SRC*XLEN-1:0]   src_data,
   output logic                      wr_en,
   output reg_addr_t                 rd_addr,
   output logic [XLEN-1:0]           rd_data,
   output logic [NUM_REGS-1:0]       busy_vec
);

   logic [NUM_SRC-1:0]  gnt_c;
   logic                accept_c;
   reg_addr_t           sel_rd_c;
   logic [XLEN-1:0]     sel_data_c;
   logic [NUM_REGS-1:0] busy_nxt_c;

   rr_arbiter #(
      .NUM_REQ (NUM_SRC)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (src_valid),
      .gnt_c (gnt_c)
   );

   assign src_ready = gnt_c;
   assign accept_c  = |gnt_c;

   // Select the granted source's payload
   always_comb begin
      sel_rd_c   = REG_ZERO;
      sel_data_c = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (gnt_c[i]) begin
            sel_rd_c   = src_rd[i*REG_AW +: REG_AW];
            sel_data_c = src_data[i*XLEN +: XLEN];
         end
      end
   end

   // Output stage; an x0 result completes the handshake but never writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en   <= 1'b0;
         rd_addr <= REG_ZERO;
         rd_data <= '0;
      end else begin
         wr_en <= accept_c && (sel_rd_c != REG_ZERO);
         if (accept_c) begin
            rd_addr <= sel_rd_c;
            rd_data <= sel_data_c;
         end
      end
   end

   // Scoreboard: commit clears, allocation sets; set is applied last so it wins
   always_comb begin
      busy_nxt_c = busy_vec;
      if (wr_en) busy_nxt_c[rd_addr] = 1'b0;
      if (alloc_valid && (alloc_rd != REG_ZERO)) busy_nxt_c[alloc_rd] = 1'b1;
      busy_nxt_c[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_vec <= '0;
      else        busy_vec <= busy_nxt_c;
   end

   // Re-allocating a register is legal only at the edge its write commits
   a_alloc_free: assert property (@(posedge clk) disable iff (!rst_n)
      (alloc_valid && (alloc_rd != REG_ZERO)) |->
         (!busy_vec[alloc_rd] || (wr_en && (rd_addr == alloc_rd))));

   // Every accepted non-x0 result must target a register allocated at issue
   a_accept_busy: assert property (@(posedge clk) disable iff (!rst_n)
      (accept_c && (sel_rd_c != REG_ZERO)) |-> busy_vec[sel_rd_c]);

   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(src_ready));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: a scoreboard queue holds the
// expected write for each cycle, pushed when stimulus is applied and popped
// after the edge, alongside a reference busy-bit model.
module tb_regfile_wb_ctrl;
   import rv_pkg::*;

   localparam int unsigned NUM_SRC = 3;
   localparam int unsigned DW      = 32;

   typedef struct packed {
      logic    we;
      wb_req_t req;
   } exp_t;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      alloc_valid;
   reg_addr_t                 alloc_rd;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC*REG_AW-1:0] src_rd;
   logic [NUM_SRC*DW-1:0]     src_data;
   logic                      wr_en;
   reg_addr_t                 rd_addr;
   logic [DW-1:0]             rd_data;
   logic [31:0]               busy_vec;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   int unsigned m_ptr;
   logic [31:0] m_busy;
   logic        m_we;
   reg_addr_t   m_rd;
   int          last_gnt;
   exp_t        sb_q[$];

   regfile_wb_ctrl #(
      .NUM_SRC (NUM_SRC),
      .XLEN    (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc_valid (alloc_valid),
      .alloc_rd    (alloc_rd),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .src_rd      (src_rd),
      .src_data    (src_data),
      .wr_en       (wr_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy_vec    (busy_vec)
   );

   always #5 clk = ~clk;

   function automatic int predict_grant(input logic [NUM_SRC-1:0] v, input int unsigned ptr);
      int start;
      start = int'(ptr);
`ifdef WB_FIXED_PRIO_EN
      start = 0;
`endif
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         int i;
         i = (start + k) % int'(NUM_SRC);
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
      src_valid[i]           = v;
      src_rd[i*REG_AW +: REG_AW] = rd;
      src_data[i*DW +: DW]   = d;
   endtask

   // One clock cycle with the inputs currently driven
   task automatic tick(input string tag);
      int                 g;
      logic [NUM_SRC-1:0] eg;
      exp_t               e;
      logic [31:0]        nb;
      #1;
      g  = predict_grant(src_valid, m_ptr);
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      n_tests++;
      if (src_ready !== eg) begin
         n_fail++;
         $display("FAIL %s src_ready: got %b, expected %b", tag, src_ready, eg);
      end
      last_gnt = g;
      if (g >= 0) begin
         e.req.rd   = src_rd[g*REG_AW +: REG_AW];
         e.req.data = src_data[g*DW +: DW];
         e.we       = (e.req.rd != REG_ZERO);
         m_ptr      = unsigned'((g + 1) % int'(NUM_SRC));
      end else begin
         e = '0;
      end
      sb_q.push_back(e);
      nb = m_busy;
      if (m_we) nb[m_rd] = 1'b0;
      if (alloc_valid && alloc_rd != REG_ZERO) nb[alloc_rd] = 1'b1;
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_tests++;
      if (wr_en !== e.we) begin
         n_fail++;
         $display("FAIL %s wr_en: got %b, expected %b", tag, wr_en, e.we);
      end
      if (e.we) begin
         n_tests++;
         if (rd_addr !== e.req.rd || rd_data !== e.req.data) begin
            n_fail++;
            $display("FAIL %s write: got x%0d=%h, expected x%0d=%h", tag, rd_addr, rd_data,
                     e.req.rd, e.req.data);
         end
      end
      m_we   = e.we;
      m_rd   = e.req.rd;
      m_busy = nb;
      n_tests++;
      if (busy_vec !== m_busy) begin
         n_fail++;
         $display("FAIL %s busy_vec: got %h, expected %h", tag, busy_vec, m_busy);
      end
   endtask

   task automatic alloc_tick(input logic [4:0] rd);
      alloc_valid = 1'b1;
      alloc_rd    = rd;
      tick("alloc");
      alloc_valid = 1'b0;
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_busy = '0;
      m_we   = 1'b0;
      m_rd   = REG_ZERO;
      sb_q.delete();
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      alloc_valid = 1'b0;
      alloc_rd    = REG_ZERO;
      src_valid   = '0;
      src_rd      = '0;
      src_data    = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (wr_en !== 1'b0 || rd_addr !== REG_ZERO || rd_data !== '0) begin
         n_fail++;
         $display("FAIL reset_out: got we=%b addr=%0d data=%h, expected 0/0/0", wr_en, rd_addr, rd_data);
      end
      n_tests++;
      if (busy_vec !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_busy: got %h, expected 0", busy_vec);
      end
      tick("idle");
      alloc_tick(5'd5);
      n_tests++;
      if (busy_vec !== 32'h20) begin
         n_fail++;
         $display("FAIL alloc_x5: got %h, expected 00000020", busy_vec);
      end
   endtask

   task automatic test_single_source();
      set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
      tick("single");
      n_tests++;
      if (last_gnt != 1 || wr_en !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL single_write: got gnt=%0d we=%b x%0d=%h, expected gnt=1 we=1 x5=deadbeef",
                  last_gnt, wr_en, rd_addr, rd_data);
      end
      set_src(1, 1'b0, 5'd0, 32'h0);
      tick("single_commit");
      n_tests++;
      if (busy_vec[5] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_clear: got busy_vec[5]=%b, expected 0", busy_vec[5]);
      end
   endtask

   task automatic test_round_robin();
      int exp_seq[6];
      int got_seq[6];
`ifdef WB_FIXED_PRIO_EN
      exp_seq = '{0, 0, 0, 0, 0, 0};
`else
      exp_seq = '{0, 1, 2, 0, 1, 2};
`endif
      do_reset();
      alloc_tick(5'd1);
      alloc_tick(5'd2);
      alloc_tick(5'd3);
      set_src(0, 1'b1, 5'd1, 32'hA0A0_0001);
      set_src(1, 1'b1, 5'd2, 32'hB1B1_0002);
      set_src(2, 1'b1, 5'd3, 32'hC2C2_0003);
      for (int c = 0; c < 6; c++) begin
         // Re-allocate each register as its write commits so it stays busy
         alloc_valid = m_we;
         alloc_rd    = m_rd;
         tick("rr");
         got_seq[c] = last_gnt;
      end
      alloc_valid = 1'b0;
      src_valid   = '0;
      for (int c = 0; c < 6; c++) begin
         n_tests++;
         if (got_seq[c] != exp_seq[c]) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got grant %0d, expected %0d", c, got_seq[c], exp_seq[c]);
         end
      end
      tick("rr_drain");
   endtask

   task automatic test_rd_zero();
      do_reset();
      alloc_tick(5'd4);
      alloc_tick(5'd6);
      set_src(0, 1'b1, 5'd0, 32'h0000_1234);
      tick("rd0");
      n_tests++;
      if (last_gnt != 0 || wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL rd0_nowrite: got gnt=%0d we=%b, expected gnt=0 we=0", last_gnt, wr_en);
      end
      set_src(0, 1'b1, 5'd4, 32'h4444_0004);
      set_src(1, 1'b1, 5'd6, 32'h6666_0006);
      tick("rd0_ptr");
      n_tests++;
`ifdef WB_FIXED_PRIO_EN
      if (last_gnt != 0) begin
`else
      if (last_gnt != 1) begin
`endif
         n_fail++;
         $display("FAIL rd0_ptr_adv: got grant %0d after x0 write", last_gnt);
      end
      if (last_gnt >= 0) src_valid[last_gnt] = 1'b0;
      tick("rd0_second");
      if (last_gnt >= 0) src_valid[last_gnt] = 1'b0;
      tick("rd0_drain");
   endtask

   task automatic test_alloc_on_commit();
      do_reset();
      alloc_tick(5'd7);
      set_src(2, 1'b1, 5'd7, 32'h7777_0007);
      tick("x7_accept");
      set_src(2, 1'b0, 5'd0, 32'h0);
      n_tests++;
      if (wr_en !== 1'b1 || rd_addr !== 5'd7) begin
         n_fail++;
         $display("FAIL x7_pending: got we=%b addr=%0d, expected we=1 addr=7", wr_en, rd_addr);
      end
      alloc_tick(5'd7);
      n_tests++;
      if (busy_vec[7] !== 1'b1) begin
         n_fail++;
         $display("FAIL x7_set_wins: got busy_vec[7]=%b, expected 1", busy_vec[7]);
      end
      tick("x7_idle");
   endtask

   task automatic test_async_reset();
      do_reset();
      alloc_tick(5'd1);
      alloc_tick(5'd2);
      alloc_tick(5'd3);
      set_src(0, 1'b1, 5'd1, 32'hFEED_0001);
      tick("pre_rst");
      set_src(0, 1'b0, 5'd0, 32'h0);
      n_tests++;
      if (wr_en !== 1'b1 || busy_vec !== 32'h0000_000E) begin
         n_fail++;
         $display("FAIL pre_rst_state: got we=%b busy=%h, expected we=1 busy=0000000e", wr_en, busy_vec);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (wr_en !== 1'b0 || busy_vec !== 32'h0 || rd_addr !== REG_ZERO) begin
         n_fail++;
         $display("FAIL async_rst: got we=%b busy=%h addr=%0d, expected 0/0/0", wr_en, busy_vec, rd_addr);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tick("post_rst_idle");
   endtask

   initial begin
      last_gnt = -1;
      test_reset();
      test_single_source();
      test_round_robin();
      test_rd_zero();
      test_alloc_on_commit();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 32×32 integer register file. It arbitrates up to NUM_SRC write-back sources onto the register file's single write port through a registered output stage. It also keeps a busy-bit scoreboard of destination registers with writes still in flight, which issue logic uses to stall RAW/WAW hazards. It sits between the execute/memory units and the register file write port.

## Interface
- NUM_SRC, 3, number of write-back sources (2..8)
- XLEN, 32, data width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alloc_valid  in  1  issue stage allocates a destination this cycle
- alloc_rd  in  5  destination register being allocated
- src_valid  in  NUM_SRC  source i presents a result
- src_ready  out  NUM_SRC  source i result accepted this cycle (one-hot or zero)
- src_rd  in  NUM_SRC×5  destination of source i
- src_data  in  NUM_SRC×XLEN  result of source i
- wr_en  out  1  register file write enable
- rd_addr  out  5  register file write address
- rd_data  out  XLEN  register file write data
- busy_vec  out  32  bit r set = write to xr pending; bit 0 always 0

## Operation
- Handshake: a transfer on source i occurs when src_valid[i] && src_ready[i]. Sources hold valid, rd and data stable until accepted. The controller never drops a valid request.
- src_ready is combinational from src_valid and the arbitration state. At most one bit is set, and the winner is granted whenever any valid is high. The write port never back-pressures.
- Round-robin: priority pointer ptr (0..NUM_SRC-1). Search order is ptr, ptr+1, …, wrapping modulo NUM_SRC. After a grant to i, ptr becomes (i+1) mod NUM_SRC. ptr is unchanged when there is no grant.
- Output stage: on acceptance, register wr_en=1, rd_addr=src_rd[i], rd_data=src_data[i]. With no acceptance, wr_en=0; addr and data hold their previous values.
- rd=0 acceptance: handshake completes and ptr advances, but wr_en stays 0 (no x0 write).
- Scoreboard: alloc_valid with alloc_rd≠0 sets busy_vec[alloc_rd] at the next edge. alloc_rd=0 is ignored.
- Busy clear: busy_vec[r] clears at the edge where the registered write (wr_en=1, rd_addr=r) commits, i.e. two edges after acceptance.
- Simultaneous set and clear of the same r: set wins, so the bit stays 1.
- Allocating an already-busy register is an issue-side protocol violation. The bit stays 1, and a simulation assertion fires.
- Acceptance of a non-busy rd≠0 is a protocol violation. The write still proceeds, and a simulation assertion fires.

## Timing
- Reset values: wr_en=0, rd_addr=0, rd_data=0, busy_vec=0, ptr=0.
- Reset is asynchronous. Assertion mid-operation discards the in-flight output stage (wr_en=0 immediately) and clears all busy bits.
- Latency: acceptance at edge N → wr_en high during cycle N..N+1 → register file written and busy bit cleared at edge N+1.
- Throughput: one write per cycle, sustained.
- Worst-case wait for a continuously valid source is NUM_SRC-1 cycles (round-robin mode).
- Register file readers see the new value from the cycle after the write edge. No bypass is provided here.

## Configuration
- WB_FIXED_PRIO_EN defined: fixed priority, where the lowest index wins and ptr is not instantiated. Starvation of high indices is allowed.
- WB_FIXED_PRIO_EN undefined (default): round-robin as described above.
- Scoreboard and output stage behaviour are identical in both modes.

## Structure
- Shared package rv_pkg provides:
  - reg_addr_t (logic [4:0])
  - XLEN constant
  - REG_ZERO constant (5'd0)
  - wb_req_t struct {rd, data}
- Sub-module rr_arbiter (NUM_REQ parameter):
  - inputs: req vector, clk/rst_n
  - output: one-hot grant
  - holds the pointer internally
  - the macro selects its fixed-priority branch
- The top level holds the output register, the scoreboard, and the assertions.

## Test plan
- Reset, then idle: wr_en=0, busy_vec=0. Alloc x5 → busy_vec=0x20 next cycle.
- Source 1 only: valid rd=5, data=0xDEADBEEF after alloc x5 → src_ready=3'b010 same cycle; next cycle wr_en=1, rd_addr=5, rd_data=0xDEADBEEF; following cycle busy_vec[5]=0.
- All three sources valid for 6 cycles (rd 1/2/3, preallocated) → grants 0,1,2,0,1,2. Under WB_FIXED_PRIO_EN, grants are 0 while it stays valid; with src_valid[0] dropped after one grant → 0,1,1,…
- Source 0 writes rd=0, data=0x1234 → src_ready[0]=1, wr_en stays 0, ptr advances to 1.
- Alloc x7 in the same cycle as the committing write to x7 → busy_vec[7] remains 1.
- rst_n low while wr_en=1 and busy_vec=0x0E → wr_en=0 and busy_vec=0 immediately, without a clock edge.
